// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: key synchronisers, debouncers, press
// detection and the run/pause/finish state machine driving the timer.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | after reset, timer held, waiting for start
// RUN   | timer counting (switch=1)
// PAUSE | timer held, start resumes, finish ends
// DONE  | finished display (finish=1), left only by reset
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_finish_n,
  output logic       switch,
  output logic       finish,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 = start key, bit 1 = finish key
  logic [1:0]       keys;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_prev;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];
  state_t           state_q;
  state_t           state_d;

  assign keys = {key_finish_n, key_start_n};

  // two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // accept a new level only after it has been stable for DEBOUNCE_CYCLES
  always_ff @(posedge clock) begin
    if (!reset) begin
      deb <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // one-cycle press pulse on each debounced falling edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      deb_prev <= 2'b11;
      press    <= 2'b00;
    end else begin
      deb_prev <= deb;
      press    <= deb_prev & ~deb;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state; finish takes priority over start in RUN and PAUSE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press[0]) state_d = RUN;
      RUN:     if (press[1]) state_d = DONE;
               else if (press[0]) state_d = PAUSE;
      PAUSE:   if (press[1]) state_d = DONE;
               else if (press[0]) state_d = RUN;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign state  = state_q;
  assign switch = (state_q == RUN);
  assign finish = (state_q == DONE);

endmodule
